pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Reset and lock supervisor directly downstream of the core PLL (74.25 MHz reference, 18.432 MHz and 133.12 MHz output families). It runs on the PLL reference clock and drives the PLL `rst` input with a timed pulse. It synchronises the PLL's asynchronous `locked` output, waits for a continuously stable lock, and only then releases the system reset consumed by the core clock domains. It retries on lock timeout, re-sequences on loss of lock, and latches a terminal fail after a bounded number of retries.

## Interface
- `RST_PULSE_CYCLES`, 16: refclk cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT_CYCLES`, 742500: cycles to wait for lock per attempt (10 ms at 74.25 MHz).
- `LOCK_STABLE_CYCLES`, 7425: cycles of continuous lock required before release (100 µs).
- `MAX_RETRIES`, 3: timeouts tolerated before FAIL.
- `SYNC_STAGES`, 2: flops in the `locked` synchroniser (≥2).
- `refclk` in 1: the block's only clock; 74.25 MHz reference.
- `rst` in 1: synchronous, active-high reset.
- `locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `pll_rst` out 1: drives the PLL `rst` input.
- `sys_reset` out 1: active-high reset to downstream logic.
- `ready` out 1: high only in RUN.
- `fail` out 1: high only in FAIL.
- `retry_count` out `$clog2(MAX_RETRIES+1)`: timeouts in the current sequence.
- `lock_lost` out 1: single-cycle pulse on loss of lock while in RUN.

## Operation
- `locked` passes through a `SYNC_STAGES` flop chain to give `locked_s`. No other logic samples `locked`.
- A single down-counter or up-counter `cnt` is shared by all states. It clears on every state transition. Its width is `$clog2` of the largest of the three cycle parameters.
- States: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL.
- **RESET_PLL**: `pll_rst`=1 and `sys_reset`=1. After `RST_PULSE_CYCLES` cycles the block moves to WAIT_LOCK.
- **WAIT_LOCK**: `pll_rst`=0 and `sys_reset`=1.
  - If `locked_s`=1, move to STABLE.
  - Otherwise, at `cnt`==`LOCK_TIMEOUT_CYCLES-1`:
    - If `retry_count`==`MAX_RETRIES`, move to FAIL.
    - Otherwise increment `retry_count` and move to RESET_PLL.
- **STABLE**: `sys_reset`=1.
  - If `locked_s`=0, return to WAIT_LOCK with a fresh timeout and no retry increment.
  - If `cnt`==`LOCK_STABLE_CYCLES-1` with `locked_s`=1, move to RUN.
- **RUN**: `sys_reset`=0 and `ready`=1.
  - If `locked_s`=0: pulse `lock_lost` for one cycle, clear `retry_count`, and move to RESET_PLL.
- **FAIL**: `pll_rst`=1, `sys_reset`=1, `fail`=1. The block holds here until `rst`; `rst` is the only exit.
- Simultaneous events:
  - Timeout and `locked_s` rising in the same WAIT_LOCK cycle: lock wins, and the block goes to STABLE.
  - `rst` overrides every state, mid-pulse or mid-count.

## Timing
- All outputs are registered and decoded from the next state. Each output changes on the same edge as its state transition.
- On the edge where `rst` is sampled high, the block forces:
  - state to RESET_PLL and `cnt` to 0;
  - `pll_rst`=1, `sys_reset`=1;
  - `ready`=0, `fail`=0, `retry_count`=0, `lock_lost`=0.
- Synchroniser latency is `SYNC_STAGES` edges from `locked` to `locked_s`.
- `pll_rst` width is exactly `RST_PULSE_CYCLES` cycles, counted from the first edge after `rst` deasserts.
- Release latency: `sys_reset` falls exactly `SYNC_STAGES + 1 + LOCK_STABLE_CYCLES` edges after the first edge that samples `locked`=1, provided `locked` stays high.
- Loss of lock in RUN: `sys_reset` rises and `lock_lost` pulses `SYNC_STAGES + 1` edges after `locked` falls. `pll_rst` rises on the same edge.
- Glitch on `locked` during STABLE: if the glitch is shorter than one cycle it may be missed. If it is captured, the stable count restarts from 0.

## Structure
- Package `pll_seq_pkg` holds:
  - the `pll_seq_state_t` enum (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL);
  - a `pll_seq_cnt_w` helper function.
- Sub-module `pll_lock_sync`: a parameterised `SYNC_STAGES` bit synchroniser with no reset on the data path. It is reused later for other clock-crossing status bits.
- The top level holds the FSM, `cnt`, `retry_count`, and the output registers.

## Test plan
Bench parameters: `RST_PULSE_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=100, `LOCK_STABLE_CYCLES`=20, `MAX_RETRIES`=2, `SYNC_STAGES`=2.
- **Clean lock.** Stimulus: release `rst`, then raise `locked` 30 cycles later. Required response: `pll_rst` is high for exactly 4 cycles, and `sys_reset` falls and `ready` rises exactly 23 edges after the first edge sampling `locked`=1.
- **Retry then lock.** Stimulus: keep `locked` low for one full timeout, then raise it. Required response: a second 4-cycle `pll_rst` pulse, `retry_count`=1, then release as in the clean-lock case.
- **Exhaust retries.** Stimulus: `locked` never rises. Required response: three timeouts, with `retry_count` reaching 2. After that `fail`=1, `pll_rst`=1 and `sys_reset`=1 are held, until `rst` restores all reset values.
- **Unstable lock.** Stimulus: `locked` goes high for 10 cycles, low for 5, then high. Required response: the stable count restarts, `retry_count` stays 0, and release is 23 edges after the final rise.
- **Loss in RUN.** Stimulus: drop `locked` while in RUN. Required response: after 3 edges, `lock_lost` pulses once, `sys_reset`=1, `ready`=0, `pll_rst` starts a 4-cycle pulse, and `retry_count`=0.
- **Reset mid-operation.** Stimulus: assert `rst` during STABLE and again during FAIL. Required response: on the next edge every output takes its reset value, and the sequence restarts with a fresh `pll_rst` pulse.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helper for the PLL lock sequencer and its testbench.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_seq_state_t;

    // Width of a counter that must reach (largest cycle count - 1).
    function automatic int pll_seq_cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop bit synchroniser; no reset on the data path so it can be reused for any status bit.
module pll_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies a stable lock, then releases system reset.
//
// state     | meaning
// RESET_PLL | PLL reset asserted for RST_PULSE_CYCLES
// WAIT_LOCK | PLL running, waiting for lock or timeout
// STABLE    | lock seen, counting continuous lock cycles
// RUN       | system reset released, watching for loss of lock
// FAIL      | retries exhausted, held until reset
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 742500,
    parameter int LOCK_STABLE_CYCLES  = 7425,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                                 i_refclk,
    input  logic                                 i_rst,
    input  logic                                 i_locked,
    output logic                                 o_pll_rst,
    output logic                                 o_sys_reset,
    output logic                                 o_ready,
    output logic                                 o_fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]     o_retry_count,
    output logic                                 o_lock_lost
);

    localparam int CNT_W   = pll_seq_cnt_w(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int RETRY_W = $clog2(MAX_RETRIES+1);

    localparam logic [CNT_W-1:0]   C_RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   C_TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   C_STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] C_MAX_RETRY = RETRY_W'(MAX_RETRIES);

    pll_seq_state_t     r_state;
    pll_seq_state_t     w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               w_lock_lost_nxt;
    logic               w_locked_s;
    logic               r_pll_rst;
    logic               r_sys_reset;
    logic               r_ready;
    logic               r_fail;
    logic               r_lock_lost;

    pll_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk (i_refclk),
        .i_d   (i_locked),
        .o_q   (w_locked_s)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_retry_nxt     = r_retry;
        w_lock_lost_nxt = 1'b0;
        case (r_state)
            RESET_PLL: begin
                if (r_cnt == C_RST_LAST) w_state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (w_locked_s) begin
                    w_state_nxt = STABLE;
                end else if (r_cnt == C_TO_LAST) begin
                    if (r_retry == C_MAX_RETRY) begin
                        w_state_nxt = FAIL;
                    end else begin
                        w_retry_nxt = r_retry + RETRY_W'(1);
                        w_state_nxt = RESET_PLL;
                    end
                end
            end
            STABLE: begin
                if (!w_locked_s)                w_state_nxt = WAIT_LOCK;
                else if (r_cnt == C_STB_LAST)   w_state_nxt = RUN;
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_lock_lost_nxt = 1'b1;
                    w_retry_nxt     = '0;
                    w_state_nxt     = RESET_PLL;
                end
            end
            FAIL:    w_state_nxt = FAIL;
            default: w_state_nxt = RESET_PLL;
        endcase
    end

    // Outputs are decoded from the next state so they move on the transition edge.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state     <= RESET_PLL;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
            r_retry     <= w_retry_nxt;
            r_pll_rst   <= (w_state_nxt == RESET_PLL) || (w_state_nxt == FAIL);
            r_sys_reset <= (w_state_nxt != RUN);
            r_ready     <= (w_state_nxt == RUN);
            r_fail      <= (w_state_nxt == FAIL);
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    assign o_pll_rst     = r_pll_rst;
    assign o_sys_reset   = r_sys_reset;
    assign o_ready       = r_ready;
    assign o_fail        = r_fail;
    assign o_retry_count = r_retry;
    assign o_lock_lost   = r_lock_lost;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer with shortened timing parameters.
module tb_pll_lock_sequencer;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [1:0] retry_count;
    logic       lock_lost;

    int checks = 0;
    int errors = 0;
    int n;
    int maxr;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (100),
        .LOCK_STABLE_CYCLES  (20),
        .MAX_RETRIES         (2),
        .SYNC_STAGES         (2)
    ) dut (
        .i_refclk      (clk),
        .i_rst         (rst),
        .i_locked      (locked),
        .o_pll_rst     (pll_rst),
        .o_sys_reset   (sys_reset),
        .o_ready       (ready),
        .o_fail        (fail),
        .o_retry_count (retry_count),
        .o_lock_lost   (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b0;
        repeat (3) step();
        chk("rst_pll_rst",   pll_rst, 1);
        chk("rst_sys_reset", sys_reset, 1);
        chk("rst_ready",     ready, 0);
        chk("rst_fail",      fail, 0);
        chk("rst_retry",     retry_count, 0);
        chk("rst_lock_lost", lock_lost, 0);

        // Clean lock
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 50) begin n++; step(); end
        chk("clean_pulse_width", n, 4);
        repeat (26) @(posedge clk);
        @(negedge clk);
        locked = 1'b1;
        n = 0;
        do begin step(); n++; end while (sys_reset && n < 200);
        chk("clean_release_edges", n, 23);
        chk("clean_ready", ready, 1);
        chk("clean_retry", retry_count, 0);

        // Loss of lock in RUN
        @(negedge clk);
        locked = 1'b0;
        n = 0;
        do begin step(); n++; end while (!lock_lost && n < 50);
        chk("loss_edges", n, 3);
        chk("loss_sys_reset", sys_reset, 1);
        chk("loss_ready", ready, 0);
        chk("loss_pll_rst", pll_rst, 1);
        chk("loss_retry", retry_count, 0);
        n = 1;
        step();
        chk("loss_pulse_single", lock_lost, 0);
        while (pll_rst && n < 50) begin n++; step(); end
        chk("loss_pulse_width", n, 4);

        // Retry then lock
        n = 0;
        do begin step(); n++; end while (!pll_rst && n < 300);
        chk("retry_timeout_edges", n, 100);
        chk("retry_count1", retry_count, 1);
        chk("retry_sys_reset", sys_reset, 1);
        n = 0;
        while (pll_rst && n < 50) begin n++; step(); end
        chk("retry_pulse_width", n, 4);
        @(negedge clk);
        locked = 1'b1;
        n = 0;
        do begin step(); n++; end while (sys_reset && n < 200);
        chk("retry_release_edges", n, 23);
        chk("retry_ready", ready, 1);
        chk("retry_count_kept", retry_count, 1);

        // Unstable lock
        @(negedge clk);
        locked = 1'b0;
        n = 0;
        do begin step(); n++; end while (!lock_lost && n < 50);
        chk("unst_loss_edges", n, 3);
        n = 0;
        while (pll_rst && n < 50) begin n++; step(); end
        @(negedge clk);
        locked = 1'b1;
        repeat (10) @(negedge clk);
        locked = 1'b0;
        repeat (5) @(negedge clk);
        chk("unst_sys_reset_held", sys_reset, 1);
        locked = 1'b1;
        n = 0;
        do begin step(); n++; end while (sys_reset && n < 200);
        chk("unst_release_edges", n, 23);
        chk("unst_retry", retry_count, 0);

        // Exhaust retries
        @(negedge clk);
        locked = 1'b0;
        n = 0;
        maxr = 0;
        do begin
            step();
            n++;
            if (int'(retry_count) > maxr) maxr = int'(retry_count);
        end while (!fail && n < 1000);
        chk("exh_fail_edges", n, 315);
        chk("exh_max_retry", maxr, 2);
        chk("exh_retry", retry_count, 2);
        repeat (50) step();
        chk("exh_fail_held", fail, 1);
        chk("exh_pll_rst", pll_rst, 1);
        chk("exh_sys_reset", sys_reset, 1);
        chk("exh_ready", ready, 0);

        // Reset during FAIL
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("frst_pll_rst",   pll_rst, 1);
        chk("frst_sys_reset", sys_reset, 1);
        chk("frst_ready",     ready, 0);
        chk("frst_fail",      fail, 0);
        chk("frst_retry",     retry_count, 0);
        chk("frst_lock_lost", lock_lost, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 50) begin n++; step(); end
        chk("frst_pulse_width", n, 4);

        // Reset during STABLE
        @(negedge clk);
        locked = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("srst_pll_rst",   pll_rst, 1);
        chk("srst_sys_reset", sys_reset, 1);
        chk("srst_ready",     ready, 0);
        chk("srst_retry",     retry_count, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 50) begin n++; step(); end
        chk("srst_pulse_width", n, 4);
        n = 0;
        do begin step(); n++; end while (sys_reset && n < 200);
        chk("srst_release_edges", n, 21);
        chk("srst_ready_after", ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
